alu32_nibble_seq: RTL



---
 rtl/alu32_nibble_seq.sv | 103 ++++++++++
 1 files changed

// File: rtl/alu32_nibble_seq.sv
// alu32_nibble_seq: multi-cycle 32-bit ALU that processes one 4-bit slice per clock, LSB nibble first.
module alu32_nibble_seq #(
    parameter int NIBBLES = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic [2:0]             op,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   c,
    output logic                   n,
    output logic                   z,
    output logic                   v
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_carry;
    logic [2:0]      r_op;
    logic [W-1:0]    r_a, r_b, r_acc;

    logic [3:0]      w_a4, w_b4, w_bx, w_slice;
    logic [4:0]      w_sum;
    logic [W-1:0]    w_res;
    logic            w_arith, w_last, w_cout, w_v;

    // Operands shift right each slice, so the active nibble is always the low one.
    assign w_a4    = r_a[3:0];
    assign w_b4    = r_b[3:0];
    assign w_arith = r_op[2] & r_op[1];
    assign w_bx    = (r_op == 3'b111) ? ~w_b4 : w_b4;
    assign w_sum   = {1'b0, w_a4} + {1'b0, w_bx} + {4'b0, r_carry};
    assign w_cout  = w_arith & w_sum[4];
    assign w_last  = (r_cnt == CW'(NIBBLES - 1));
    assign w_slice = (r_op == 3'b000) ? ~w_a4 :
                     (r_op == 3'b001) ? ~w_b4 :
                     (r_op == 3'b010) ? (w_a4 & w_b4) :
                     (r_op == 3'b011) ? (w_a4 | w_b4) :
                     (r_op == 3'b100) ? (w_a4 ^ w_b4) :
                     (r_op == 3'b101) ? ~(w_a4 ^ w_b4) : w_sum[3:0];
    assign w_res   = {w_slice, r_acc[W-1:4]};
    // On the last slice the low nibbles hold A[31]/B[31]; sub flips the sign-agreement test.
    assign w_v     = w_arith & (((w_a4[3] ^ w_b4[3]) == r_op[0])) & (w_slice[3] != w_a4[3]);

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            result  <= '0;
            c       <= 1'b0;
            n       <= 1'b0;
            z       <= 1'b0;
            v       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_a     <= a;
                r_b     <= b;
                r_op    <= op;
                r_cnt   <= '0;
                r_carry <= (op == 3'b111);
            end else if (r_state == RUN) begin
                r_a     <= r_a >> 4;
                r_b     <= r_b >> 4;
                r_acc   <= w_res;
                r_carry <= w_cout;
                r_cnt   <= r_cnt + 1'b1;
                if (w_last) begin
                    result <= w_res;
                    c      <= w_cout;
                    n      <= w_res[W-1];
                    z      <= ~|w_res;
                    v      <= w_v;
                end
            end
        end
    end
endmodule
